mem_responder: RTL and testbench

//   Memory-side responder for the datapath's imem/dmem request interface (address/read/write/wmask/

---
 rtl/mem_responder.sv | 136 +++++++++++++
 tb/tb_mem_responder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Word-SRAM memory responder with a fixed, parameterised response latency.
// Revision : 1.0
// ============================================================================
module mem_responder #(
   parameter int          DEPTH_LOG2 = 10,
   parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
   parameter int          LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_address,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [3:0]  mem_wmask,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_resp,
   output logic        mem_err
);

   localparam int         c_depth    = 1 << DEPTH_LOG2;
   localparam logic [3:0] c_cnt_init = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_wmask;
   logic        r_read;
   logic        r_write;
   logic [31:0] r_mem [c_depth];

   logic                  w_accept;
   logic                  w_direct;
   logic                  w_finish;
   logic [31:0]           w_addr;
   logic [31:0]           w_wdata;
   logic [3:0]            w_wmask;
   logic                  w_op_read;
   logic                  w_op_write;
   logic [31:0]           w_off;
   logic                  w_in_range;
   logic [DEPTH_LOG2-1:0] w_index;
   logic                  w_err;
   logic                  w_commit;

   assign w_accept = (r_state == S_IDLE) && (mem_read || mem_write);
   // With single-cycle latency the access happens on the accepting edge, so live inputs are used.
   assign w_direct = w_accept && (LATENCY == 1);
   assign w_finish = ((r_state == S_WAIT) && (r_cnt == 4'd1)) || w_direct;

   assign w_addr     = w_direct ? mem_address : r_addr;
   assign w_wdata    = w_direct ? mem_wdata   : r_wdata;
   assign w_wmask    = w_direct ? mem_wmask   : r_wmask;
   assign w_op_read  = w_direct ? mem_read    : r_read;
   assign w_op_write = w_direct ? mem_write   : r_write;

   // Unsigned wrap makes addresses below the base land far out of range.
   assign w_off      = w_addr - BASE_ADDR;
   assign w_in_range = (w_off[31:DEPTH_LOG2+2] == '0);
   assign w_index    = w_off[DEPTH_LOG2+1:2];
   assign w_err      = ~w_in_range | (w_op_read & w_op_write);
   assign w_commit   = w_finish & w_op_write & w_in_range;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= 4'd0;
         r_addr    <= 32'd0;
         r_wdata   <= 32'd0;
         r_wmask   <= 4'd0;
         r_read    <= 1'b0;
         r_write   <= 1'b0;
         mem_resp  <= 1'b0;
         mem_err   <= 1'b0;
         mem_rdata <= 32'd0;
      end else begin
         mem_resp <= 1'b0;
         mem_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_addr  <= mem_address;
                  r_wdata <= mem_wdata;
                  r_wmask <= mem_wmask;
                  r_read  <= mem_read;
                  r_write <= mem_write;
                  r_cnt   <= c_cnt_init;
                  r_state <= (LATENCY > 1) ? S_WAIT : S_RESP;
               end
            end
            S_WAIT: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) begin
                  r_state <= S_RESP;
               end
            end
            S_RESP: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
         if (w_finish) begin
            mem_resp <= 1'b1;
            mem_err  <= w_err;
            if (w_op_read && !w_op_write) begin
               mem_rdata <= w_in_range ? r_mem[w_index] : 32'd0;
            end
         end
      end
   end

   // Array is deliberately not reset; a reset edge also blocks any pending commit.
   always_ff @(posedge clk) begin
      if (w_commit && !rst) begin
         for (int b = 0; b < 4; b++) begin
            if (w_wmask[b]) begin
               r_mem[w_index][8*b +: 8] <= w_wdata[8*b +: 8];
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// Directed and model-checked bench for mem_responder at LATENCY 2, 1 and 15.
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr  [3];
   logic [31:0] wdata [3];
   logic [31:0] rdata [3];
   logic [3:0]  wmask [3];
   logic        rd    [3];
   logic        wr    [3];
   logic        resp  [3];
   logic        err   [3];

   int checks   = 0;
   int failures = 0;
   int pulses0  = 0;
   int lat [3]  = '{2, 1, 15};

   always #5 clk = ~clk;

   mem_responder #(.DEPTH_LOG2(10), .BASE_ADDR(32'h4000_0000), .LATENCY(2)) u_dut2 (
      .clk(clk), .rst(rst), .mem_address(addr[0]), .mem_read(rd[0]), .mem_write(wr[0]),
      .mem_wmask(wmask[0]), .mem_wdata(wdata[0]), .mem_rdata(rdata[0]), .mem_resp(resp[0]),
      .mem_err(err[0]));

   mem_responder #(.DEPTH_LOG2(10), .BASE_ADDR(32'h4000_0000), .LATENCY(1)) u_dut1 (
      .clk(clk), .rst(rst), .mem_address(addr[1]), .mem_read(rd[1]), .mem_write(wr[1]),
      .mem_wmask(wmask[1]), .mem_wdata(wdata[1]), .mem_rdata(rdata[1]), .mem_resp(resp[1]),
      .mem_err(err[1]));

   mem_responder #(.DEPTH_LOG2(10), .BASE_ADDR(32'h4000_0000), .LATENCY(15)) u_dut15 (
      .clk(clk), .rst(rst), .mem_address(addr[2]), .mem_read(rd[2]), .mem_write(wr[2]),
      .mem_wmask(wmask[2]), .mem_wdata(wdata[2]), .mem_rdata(rdata[2]), .mem_resp(resp[2]),
      .mem_err(err[2]));

   always @(negedge clk) begin
      if (resp[0] === 1'b1) pulses0 <= pulses0 + 1;
   end

   initial begin
      #300000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Called at a negedge in an idle cycle; returns at the negedge of the idle cycle after resp.
   task automatic req(input int d, input logic r, input logic w, input logic [31:0] a,
                      input logic [3:0] m, input logic [31:0] wd,
                      output logic [31:0] rdo, output logic erro);
      int n;
      addr[d] = a; rd[d] = r; wr[d] = w; wmask[d] = m; wdata[d] = wd;
      n = 0;
      do begin
         cycle();
         n++;
      end while (resp[d] !== 1'b1 && n < 40);
      rdo  = rdata[d];
      erro = err[d];
      rd[d] = 1'b0; wr[d] = 1'b0;
      check($sformatf("latency_d%0d_a%h", d, a), n, lat[d]);
      cycle();
      check($sformatf("resp_pulse_end_d%0d", d), {31'd0, resp[d]}, 32'd0);
      check($sformatf("err_idle_d%0d", d), {31'd0, err[d]}, 32'd0);
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] m);
      logic [31:0] res;
      res = old;
      for (int b = 0; b < 4; b++) if (m[b]) res[8*b +: 8] = nw[8*b +: 8];
      return res;
   endfunction

   initial begin
      logic [31:0] rv;
      logic        ev;
      logic [31:0] model [16];
      int          n;

      rst = 1'b1;
      for (int d = 0; d < 3; d++) begin
         addr[d] = '0; wdata[d] = '0; wmask[d] = '0; rd[d] = 1'b0; wr[d] = 1'b0;
      end
      cycle();
      cycle();
      for (int d = 0; d < 3; d++) begin
         check($sformatf("reset_resp_d%0d", d), {31'd0, resp[d]}, 32'd0);
         check($sformatf("reset_err_d%0d", d), {31'd0, err[d]}, 32'd0);
         check($sformatf("reset_rdata_d%0d", d), rdata[d], 32'd0);
      end
      rst = 1'b0;
      cycle();

      // Full write then readback
      req(0, 1'b0, 1'b1, 32'h4000_0010, 4'hF, 32'hDEAD_BEEF, rv, ev);
      check("t1_write_err", {31'd0, ev}, 32'd0);
      req(0, 1'b1, 1'b0, 32'h4000_0010, 4'h0, 32'h0, rv, ev);
      check("t1_read_data", rv, 32'hDEAD_BEEF);
      check("t1_read_err", {31'd0, ev}, 32'd0);

      // Partial write; rdata holds across the write
      req(0, 1'b0, 1'b1, 32'h4000_0010, 4'b0101, 32'h1122_3344, rv, ev);
      check("t2_rdata_hold", rv, 32'hDEAD_BEEF);
      req(0, 1'b1, 1'b0, 32'h4000_0010, 4'h0, 32'h0, rv, ev);
      check("t2_merge", rv, 32'hDE22_BE44);
      req(0, 1'b0, 1'b1, 32'h4000_0010, 4'h0, 32'hFFFF_FFFF, rv, ev);
      req(0, 1'b1, 1'b0, 32'h4000_0010, 4'h0, 32'h0, rv, ev);
      check("t2_zero_mask", rv, 32'hDE22_BE44);

      // Back-to-back reads with request held through the RESP cycle
      req(0, 1'b0, 1'b1, 32'h4000_0014, 4'hF, 32'h0102_0304, rv, ev);
      pulses0 = 0;
      addr[0] = 32'h4000_0010; rd[0] = 1'b1;
      n = 0;
      do begin cycle(); n++; end while (resp[0] !== 1'b1 && n < 40);
      check("t3_first_lat", n, 2);
      check("t3_first_data", rdata[0], 32'hDE22_BE44);
      cycle();
      check("t3_resp_single", {31'd0, resp[0]}, 32'd0);
      addr[0] = 32'h4000_0014;
      n = 0;
      do begin cycle(); n++; end while (resp[0] !== 1'b1 && n < 40);
      check("t3_spacing", n + 1, 3);
      check("t3_second_data", rdata[0], 32'h0102_0304);
      rd[0] = 1'b0;
      cycle();
      cycle();
      cycle();
      check("t3_pulse_count", pulses0, 2);

      // Out-of-range accesses and protocol violation
      req(0, 1'b0, 1'b1, 32'h4000_0000, 4'hF, 32'hA5A5_A5A5, rv, ev);
      req(0, 1'b0, 1'b1, 32'h4000_0FFC, 4'hF, 32'h5A5A_5A5A, rv, ev);
      check("t4_last_word_err", {31'd0, ev}, 32'd0);
      req(0, 1'b1, 1'b0, 32'h3FFF_FFFC, 4'h0, 32'h0, rv, ev);
      check("t4_below_data", rv, 32'd0);
      check("t4_below_err", {31'd0, ev}, 32'd1);
      req(0, 1'b1, 1'b0, 32'h4000_0FFC, 4'h0, 32'h0, rv, ev);
      check("t4_last_word_data", rv, 32'h5A5A_5A5A);
      req(0, 1'b1, 1'b0, 32'h4000_1000, 4'h0, 32'h0, rv, ev);
      check("t4_above_data", rv, 32'd0);
      check("t4_above_err", {31'd0, ev}, 32'd1);
      req(0, 1'b0, 1'b1, 32'h4000_1000, 4'hF, 32'hFFFF_FFFF, rv, ev);
      check("t4_wr_above_err", {31'd0, ev}, 32'd1);
      req(0, 1'b0, 1'b1, 32'h3FFF_FFFC, 4'hF, 32'hFFFF_FFFF, rv, ev);
      check("t4_wr_below_err", {31'd0, ev}, 32'd1);
      req(0, 1'b1, 1'b0, 32'h4000_0000, 4'h0, 32'h0, rv, ev);
      check("t4_word0_intact", rv, 32'hA5A5_A5A5);
      req(0, 1'b1, 1'b0, 32'h4000_0FFC, 4'h0, 32'h0, rv, ev);
      check("t4_last_intact", rv, 32'h5A5A_5A5A);
      req(0, 1'b1, 1'b1, 32'h4000_0018, 4'hF, 32'h7777_8888, rv, ev);
      check("t4_both_err", {31'd0, ev}, 32'd1);
      req(0, 1'b1, 1'b0, 32'h4000_0018, 4'h0, 32'h0, rv, ev);
      check("t4_both_as_write", rv, 32'h7777_8888);

      // Reset during WAIT abandons the pending write
      req(0, 1'b0, 1'b1, 32'h4000_0020, 4'hF, 32'hCAFE_F00D, rv, ev);
      req(0, 1'b1, 1'b0, 32'h4000_0020, 4'h0, 32'h0, rv, ev);
      check("t5_pre_read", rv, 32'hCAFE_F00D);
      addr[0] = 32'h4000_0020; wr[0] = 1'b1; wmask[0] = 4'hF; wdata[0] = 32'h1234_5678;
      cycle();
      rst = 1'b1;
      #1;
      check("t5_rst_resp", {31'd0, resp[0]}, 32'd0);
      check("t5_rst_err", {31'd0, err[0]}, 32'd0);
      check("t5_rst_rdata", rdata[0], 32'd0);
      wr[0] = 1'b0;
      cycle();
      rst = 1'b0;
      cycle();
      check("t5_no_resp_after", {31'd0, resp[0]}, 32'd0);
      req(0, 1'b1, 1'b0, 32'h4000_0020, 4'h0, 32'h0, rv, ev);
      check("t5_write_abandoned", rv, 32'hCAFE_F00D);

      // Random traffic against a reference array for LATENCY 1 and 15
      for (int d = 1; d < 3; d++) begin
         for (int i = 0; i < 16; i++) begin
            model[i] = $urandom;
            req(d, 1'b0, 1'b1, 32'h4000_0100 + 32'(4 * i), 4'hF, model[i], rv, ev);
         end
         for (int k = 0; k < 40; k++) begin
            int          idx;
            logic [3:0]  m;
            logic [31:0] wd;
            idx = $urandom_range(0, 15);
            m   = 4'($urandom_range(0, 15));
            wd  = $urandom;
            if ($urandom_range(0, 1) == 1) begin
               req(d, 1'b0, 1'b1, 32'h4000_0100 + 32'(4 * idx), m, wd, rv, ev);
               model[idx] = merge(model[idx], wd, m);
            end else begin
               req(d, 1'b1, 1'b0, 32'h4000_0100 + 32'(4 * idx), 4'h0, 32'h0, rv, ev);
               check($sformatf("t6_d%0d_rd%0d_idx%0d", d, k, idx), rv, model[idx]);
            end
            check($sformatf("t6_d%0d_err%0d", d, k), {31'd0, ev}, 32'd0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
